// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared encodings for the PC / instruction-register unit:
//                next-PC select codes, the halt instruction loaded on a
//                fetch timeout, the default timeout and the fetch FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Next-PC source select
    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'b00,   // PC + 4
        PCSRC_BRANCH = 2'b01,   // PC + 4 + (sext(imm16) << 2)
        PCSRC_JR     = 2'b10,   // register jump
        PCSRC_JABS   = 2'b11    // absolute jump within the current 256 MB region
    } pcsrc_e;

    // Instruction substituted when a fetch times out (opcode 6'b111111)
    localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

    // Default number of WAIT cycles tolerated before a fetch is aborted
    localparam int TIMEOUT_DEFAULT = 15;

    // Fetch FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_mux
//  Description : Combinational next-PC selection (sequential, branch,
//                register jump, absolute jump). All arithmetic wraps mod 2^32.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_mux
    import cpu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pcsrc_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] addr26_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] pc_next_o
);

    logic [31:0] w_pc4;
    logic [31:0] w_branch_off;

    assign w_pc4        = pc_i + 32'd4;
    assign w_branch_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};

    // Select the next PC; the low two bits of a register target are cleared
    // so the PC always stays word aligned.
    always_comb begin
        pc_next_o = w_pc4;
        case (pcsrc_e'(pcsrc_i))
            PCSRC_SEQ:    pc_next_o = w_pc4;
            PCSRC_BRANCH: pc_next_o = w_pc4 + w_branch_off;
            PCSRC_JR:     pc_next_o = jr_addr_i & 32'hFFFF_FFFC;
            PCSRC_JABS:   pc_next_o = {w_pc4[31:28], addr26_i, 2'b00};
            default:      pc_next_o = w_pc4;
        endcase
    end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/pc_ir_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ir_unit
//  Description : Program counter and instruction register with a two-state
//                fetch FSM talking to a handshaked instruction memory.
//                A fetch that sees no ack within TIMEOUT+1 wait cycles loads
//                the halt instruction and raises a sticky error.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_ir_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic        IRWre,
    input  logic        InsMemRW,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] jr_addr,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [5:0]  Opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [15:0] imm16,
    output logic [25:0] addr26,
    output logic        busy,
    output logic        ir_valid,
    output logic        fetch_err,
    output logic        pc_wre_lost
);

    localparam int            CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ir_valid_q, ir_valid_d;
    logic          fetch_err_q, fetch_err_d;
    logic          lost_q, lost_d;

    logic          w_launch;
    logic          w_ack;
    logic          w_timeout;
    logic [31:0]   w_pc_next;

    pc_next_mux u_pc_next_mux (
        .pc_i      (pc_q),
        .pcsrc_i   (PCSrc),
        .imm16_i   (ir_q[15:0]),
        .addr26_i  (ir_q[25:0]),
        .jr_addr_i (jr_addr),
        .pc_next_o (w_pc_next)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: launch from IDLE, finish in WAIT on ack or timeout.
    // Ack is tested first so an ack on the timeout cycle wins.
    always_comb begin
        state_d   = state_q;
        w_launch  = 1'b0;
        w_ack     = 1'b0;
        w_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (IRWre && InsMemRW) begin
                    w_launch = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    w_ack   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == C_TIMEOUT) begin
                    w_timeout = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: a request is outstanding exactly while in WAIT
    always_comb begin
        imem_req = (state_q == ST_WAIT);
        busy     = (state_q == ST_WAIT);
    end

    // Datapath next values. The fetch address is latched at launch so a PC
    // write in the same cycle does not disturb the outstanding request.
    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        addr_d      = addr_q;
        cnt_d       = '0;
        ir_valid_d  = w_ack | w_timeout;
        fetch_err_d = fetch_err_q;
        lost_d      = lost_q;

        if (PCWre) begin
            if (state_q == ST_IDLE) begin
                pc_d = w_pc_next;
            end else begin
                lost_d = 1'b1;
            end
        end

        if (w_launch) begin
            addr_d = pc_q;
        end

        if ((state_q == ST_WAIT) && !w_ack && !w_timeout) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (w_ack) begin
            ir_d = imem_rdata;
        end else if (w_timeout) begin
            ir_d        = HALT_INSTR;
            fetch_err_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q        <= '0;
            ir_q        <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
            lost_q      <= lost_d;
        end
    end

    assign PC          = pc_q;
    assign imem_addr   = addr_q;
    assign ir_valid    = ir_valid_q;
    assign fetch_err   = fetch_err_q;
    assign pc_wre_lost = lost_q;

    assign Opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign sa     = ir_q[10:6];
    assign imm16  = ir_q[15:0];
    assign addr26 = ir_q[25:0];

endmodule : pc_ir_unit
`default_nettype wire

// File: tb/tb_pc_ir_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_ir_unit
//  Description : Self-checking bench for pc_ir_unit. Expected instruction
//                words are queued when a fetch is issued and compared when
//                ir_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ir_unit;

    localparam int          TB_TIMEOUT = 15;
    localparam logic [31:0] C_HALT     = 32'hFC00_0000;

    logic        CLK;
    logic        Reset;
    logic        PCWre;
    logic        IRWre;
    logic        InsMemRW;
    logic [1:0]  PCSrc;
    logic [31:0] jr_addr;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [5:0]  Opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic        busy;
    logic        ir_valid;
    logic        fetch_err;
    logic        pc_wre_lost;

    int          total;
    int          bad;
    logic [31:0] exp_q[$];

    pc_ir_unit #(
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PCWre      (PCWre),
        .IRWre      (IRWre),
        .InsMemRW   (InsMemRW),
        .PCSrc      (PCSrc),
        .jr_addr    (jr_addr),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PC         (PC),
        .Opcode     (Opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .sa         (sa),
        .imm16      (imm16),
        .addr26     (addr26),
        .busy       (busy),
        .ir_valid   (ir_valid),
        .fetch_err  (fetch_err),
        .pc_wre_lost(pc_wre_lost)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic set_pc_jr(input logic [31:0] target);
        PCSrc   = 2'b10;
        jr_addr = target;
        PCWre   = 1'b1;
        step();
        PCWre   = 1'b0;
    endtask

    // Issue one fetch; ack_cyc is the WAIT cycle (1-based) carrying the ack,
    // 0 means no ack at all.
    task automatic fetch(input logic [31:0] word, input int ack_cyc,
                         input logic [31:0] exp_addr, input logic with_pcwre);
        int c;
        int busy_cnt;
        bit got;
        int exp_busy;
        if (ack_cyc >= 1 && ack_cyc <= TB_TIMEOUT + 1) begin
            exp_q.push_back(word);
            exp_busy = ack_cyc;
        end else begin
            exp_q.push_back(C_HALT);
            exp_busy = TB_TIMEOUT + 1;
        end
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
        PCWre    = with_pcwre;
        PCSrc    = 2'b00;
        step();
        IRWre    = 1'b0;
        PCWre    = 1'b0;
        check("req_addr", imem_addr, exp_addr);
        check("req_high", 32'(imem_req), 32'd1);
        busy_cnt = 0;
        got      = 1'b0;
        c        = 1;
        while (!got && c <= 40) begin
            if (busy) busy_cnt++;
            if (c == ack_cyc) begin
                imem_ack   = 1'b1;
                imem_rdata = word;
            end else begin
                imem_rdata = 32'hA5A5_5A5A;
            end
            step();
            imem_ack = 1'b0;
            if (ir_valid) got = 1'b1;
            else c++;
        end
        check("ir_valid_seen", 32'(got), 32'd1);
        if (exp_q.size() > 0) check("ir_word", {Opcode, addr26}, exp_q.pop_front());
        check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        check("busy_after", 32'(busy), 32'd0);
        step();
        check("ir_valid_pulse", 32'(ir_valid), 32'd0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        Reset      = 1'b0;
        PCWre      = 1'b0;
        IRWre      = 1'b0;
        InsMemRW   = 1'b0;
        PCSrc      = 2'b00;
        jr_addr    = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;

        // Reset state
        do_reset();
        check("rst_pc", PC, 32'h0);
        check("rst_ir", {Opcode, addr26}, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_lost", 32'(pc_wre_lost), 32'd0);

        // Basic fetch, ack in third wait cycle
        fetch(32'h8C22_0004, 3, 32'h0, 1'b0);
        check("lw_opcode", 32'(Opcode), 32'h23);
        check("lw_rs", 32'(rs), 32'd1);
        check("lw_rt", 32'(rt), 32'd2);
        check("lw_imm", 32'(imm16), 32'd4);

        // Ack while idle is ignored
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack   = 1'b0;
        check("idle_ack_valid", 32'(ir_valid), 32'd0);
        check("idle_ack_ir", {Opcode, addr26}, 32'h8C22_0004);

        // Fetch request without read permission does nothing
        IRWre    = 1'b1;
        InsMemRW = 1'b0;
        step();
        IRWre    = 1'b0;
        check("noperm_busy", 32'(busy), 32'd0);
        step();
        check("noperm_req", 32'(imem_req), 32'd0);

        // Register jump clears the low bits, then backward branch
        set_pc_jr(32'h0000_0103);
        check("jr_pc100", PC, 32'h0000_0100);
        fetch(32'h1000_FFFE, 1, 32'h0000_0100, 1'b0);
        PCSrc = 2'b01;
        PCWre = 1'b1;
        step();
        PCWre = 1'b0;
        check("branch_back", PC, 32'h0000_00FC);

        // Sequential wrap
        set_pc_jr(32'hFFFF_FFFC);
        PCSrc = 2'b00;
        PCWre = 1'b1;
        step();
        PCWre = 1'b0;
        check("pc4_wrap", PC, 32'h0);

        // Absolute jump keeps the upper nibble of PC+4
        set_pc_jr(32'h4000_0010);
        fetch(32'h0800_0040, 2, 32'h4000_0010, 1'b0);
        PCSrc = 2'b11;
        PCWre = 1'b1;
        step();
        PCWre = 1'b0;
        check("jabs", PC, 32'h4000_0100);
        set_pc_jr(32'h0000_1237);
        check("jr_1234", PC, 32'h0000_1234);

        // Timeout loads halt and raises the sticky error
        fetch(32'h1234_5678, 0, 32'h0000_1234, 1'b0);
        check("to_opcode", 32'(Opcode), 32'h3F);
        check("to_err", 32'(fetch_err), 32'd1);
        check("to_idle_req", 32'(imem_req), 32'd0);

        // Ack on the last allowed cycle wins
        do_reset();
        check("err_cleared", 32'(fetch_err), 32'd0);
        fetch(32'h2442_0001, TB_TIMEOUT + 1, 32'h0, 1'b0);
        check("late_ack_err", 32'(fetch_err), 32'd0);

        // Fetch and PC write together: fetch at old PC, PC advances
        fetch(32'h0000_0020, 1, 32'h0, 1'b1);
        check("same_cycle_pc", PC, 32'h4);

        // PC write during WAIT is dropped and flagged
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
        step();
        IRWre    = 1'b0;
        PCSrc    = 2'b00;
        PCWre    = 1'b1;
        step();
        PCWre    = 1'b0;
        check("wait_pc_hold", PC, 32'h4);
        check("wait_lost", 32'(pc_wre_lost), 32'd1);
        check("wait_busy", 32'(busy), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
        step();
        imem_ack   = 1'b0;
        check("wait_ack_valid", 32'(ir_valid), 32'd1);
        check("wait_ack_op", 32'(Opcode), 32'h04);
        step();
        step();
        check("lost_sticky", 32'(pc_wre_lost), 32'd1);

        // Reset during WAIT discards a coincident ack
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
        step();
        IRWre      = 1'b0;
        Reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h7777_7777;
        step();
        Reset      = 1'b0;
        imem_ack   = 1'b0;
        check("rstwait_ir", {Opcode, addr26}, 32'h0);
        check("rstwait_req", 32'(imem_req), 32'd0);
        check("rstwait_valid", 32'(ir_valid), 32'd0);
        check("rstwait_lost", 32'(pc_wre_lost), 32'd0);
        check("rstwait_pc", PC, 32'h0);
        step();
        check("rstwait_valid2", 32'(ir_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_ir_unit
`default_nettype wire
